logic_op_scheduler: RTL and testbench

LOGIC_OP_SCHEDULER -- requirements
Module: logic_op_scheduler

---
 rtl/logic_op_scheduler_pkg.sv | 24 ++
 rtl/logic_op_scheduler_if.sv | 43 ++++
 rtl/logic_op_scheduler_logic_unit.sv | 28 ++
 rtl/logic_op_scheduler.sv | 125 ++++++++++++
 tb/tb_logic_op_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_op_scheduler_pkg.sv
// Shared opcode, FSM state and width definitions for the logic-op scheduler.
// Pure declarations: no latency, no backpressure.
package logic_op_scheduler_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOTA = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTB = 3'd6,
    OP_NAND = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_op_scheduler_if.sv
// Two requester command channels plus one response channel (valid/ready).
// slave = scheduler side, master = requesters and response consumer.
interface logic_op_scheduler_if
  import logic_op_scheduler_pkg::*;
  #(parameter int W = W_DEFAULT);

  logic         req0_valid;
  logic         req0_ready;
  logic [2:0]   req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [2:0]   req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_y;
  logic         rsp_id;
  logic [7:0]   done_count;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_y, rsp_id, done_count,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_y, rsp_id, done_count,
    output rsp_ready
  );

endinterface

// File: rtl/logic_op_scheduler_logic_unit.sv
// Bitwise logic datapath: y = f(op, a, b) over W bits.
// Purely combinational, no backpressure.
module logic_unit
  import logic_op_scheduler_pkg::*;
  #(parameter int W = W_DEFAULT)
  (
    input  op_e          i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
  );

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_NOTA: o_y = ~i_a;
      OP_NOR:  o_y = ~(i_a | i_b);
      OP_XNOR: o_y = ~(i_a ^ i_b);
      OP_NOTB: o_y = ~i_b;
      OP_NAND: o_y = ~(i_a & i_b);
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_scheduler.sv
// Two-requester round-robin logic-op scheduler: accept -> rsp_valid two cycles later.
// Accepts only in IDLE; response held stable until rsp_ready, so one command per 3 cycles at best.
module logic_op_scheduler
  import logic_op_scheduler_pkg::*;
  #(parameter int W = W_DEFAULT)
  (
    input  logic                 clk,
    input  logic                 rst,
    logic_op_scheduler_if.slave  bus
  );

  state_e       r_state;
  state_e       w_next_state;
  logic         r_last_grant;
  op_e          r_op;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_id;
  logic         r_rsp_valid;
  logic [W-1:0] r_rsp_y;
  logic         r_rsp_id;
  logic [7:0]   r_done_count;

  logic         w_grant_vld;
  logic         w_grant_id;
  logic         w_req0_rdy;
  logic         w_req1_rdy;
  logic         w_accept;
  logic         w_rsp_fire;
  logic [W-1:0] w_y;

  // Ties go to the requester that did not win last time.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = ~r_last_grant;
    end else if (bus.req0_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b0;
    end else if (bus.req1_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = EXEC;
      EXEC:    w_next_state = RESP;
      RESP:    if (w_rsp_fire) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: ready only toward the granted requester, and never while in reset.
  always_comb begin
    w_req0_rdy = 1'b0;
    w_req1_rdy = 1'b0;
    if ((r_state == IDLE) && !rst && w_grant_vld) begin
      w_req0_rdy = ~w_grant_id;
      w_req1_rdy = w_grant_id;
    end
  end

  assign w_accept   = w_req0_rdy | w_req1_rdy;
  assign w_rsp_fire = r_rsp_valid & bus.rsp_ready;

  logic_unit #(.W(W)) u_logic_unit (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_op         <= OP_AND;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_y      <= '0;
      r_rsp_id     <= 1'b0;
      r_done_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_op         <= w_grant_id ? op_e'(bus.req1_op) : op_e'(bus.req0_op);
        r_a          <= w_grant_id ? bus.req1_a : bus.req0_a;
        r_b          <= w_grant_id ? bus.req1_b : bus.req0_b;
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == EXEC) begin
        r_rsp_y     <= w_y;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_fire) begin
        r_rsp_valid  <= 1'b0;
        r_done_count <= r_done_count + 8'd1;
      end
    end
  end

  assign bus.req0_ready = w_req0_rdy;
  assign bus.req1_ready = w_req1_rdy;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_y      = r_rsp_y;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.done_count = r_done_count;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed bench for logic_op_scheduler: reset, all opcodes, arbitration,
// response stall, mid-flight reset, operand isolation and done_count wrap.
module tb_logic_op_scheduler;
  import logic_op_scheduler_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  logic [7:0] exp_count;

  always #5 clk = ~clk;

  logic_op_scheduler_if #(.W(W)) bus ();

  logic_op_scheduler #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_op    = 3'd0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_valid = 1'b0;
    bus.req1_op    = 3'd0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.rsp_ready  = 1'b1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_count = 8'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst = 1'b1;
    step();
    step();
    #1;
    total++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready: got %b want 00", {bus.req1_ready, bus.req0_ready});
    end
    total++;
    if (bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
    end
    total++;
    if (bus.done_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_done_count: got %h want 00", bus.done_count);
    end
    total++;
    if ({bus.rsp_id, bus.rsp_y} !== 9'd0) begin
      bad++;
      $display("FAIL reset_rsp_id_y: got %b/%h want 0/00", bus.rsp_id, bus.rsp_y);
    end
    idle_inputs();
    rst = 1'b0;
    exp_count = 8'd0;
    step();
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_tbl [8];
    exp_tbl = '{8'h48, 8'hEB, 8'hA3, 8'h35, 8'h14, 8'h5C, 8'h96, 8'hB7};
    for (int op = 0; op < 8; op++) begin
      bus.req0_valid = 1'b1;
      bus.req0_op    = 3'(op);
      bus.req0_a     = 8'hCA;
      bus.req0_b     = 8'h69;
      #1;
      total++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
        bad++;
        $display("FAIL ops_ready op=%0d: got %b want 01", op, {bus.req1_ready, bus.req0_ready});
      end
      step();
      bus.req0_valid = 1'b0;
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL ops_early_valid op=%0d: got %b want 0", op, bus.rsp_valid);
      end
      step();
      total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y} !== {1'b1, 1'b0, exp_tbl[op]}) begin
        bad++;
        $display("FAIL ops_rsp op=%0d: got v=%b id=%b y=%h want v=1 id=0 y=%h",
                 op, bus.rsp_valid, bus.rsp_id, bus.rsp_y, exp_tbl[op]);
      end
      step();
      exp_count = exp_count + 8'd1;
      total++;
      if ({bus.rsp_valid, bus.done_count} !== {1'b0, exp_count}) begin
        bad++;
        $display("FAIL ops_done op=%0d: got v=%b cnt=%h want v=0 cnt=%h",
                 op, bus.rsp_valid, bus.done_count, exp_count);
      end
    end
  endtask

  task automatic test_alternate();
    logic       exp_id;
    logic [7:0] exp_y;
    apply_reset();
    bus.req0_valid = 1'b1;
    bus.req0_op    = 3'(OP_XOR);
    bus.req0_a     = 8'hF0;
    bus.req0_b     = 8'h3C;
    bus.req1_valid = 1'b1;
    bus.req1_op    = 3'(OP_AND);
    bus.req1_a     = 8'hF0;
    bus.req1_b     = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 1);
      exp_y  = exp_id ? 8'h30 : 8'hCC;
      #1;
      total++;
      if ({bus.req1_ready, bus.req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL alt_grant k=%0d: got %b want id %0d", k, {bus.req1_ready, bus.req0_ready}, exp_id);
      end
      step();
      step();
      total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y} !== {1'b1, exp_id, exp_y}) begin
        bad++;
        $display("FAIL alt_rsp k=%0d: got v=%b id=%b y=%h want v=1 id=%b y=%h",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_y, exp_id, exp_y);
      end
      step();
      exp_count = exp_count + 8'd1;
    end
    idle_inputs();
    total++;
    if (bus.done_count !== exp_count) begin
      bad++;
      $display("FAIL alt_done: got %h want %h", bus.done_count, exp_count);
    end
  endtask

  task automatic test_stall();
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_op    = 3'(OP_OR);
    bus.req0_a     = 8'h12;
    bus.req0_b     = 8'h40;
    #1;
    step();
    bus.req1_valid = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.req1_ready, bus.req0_ready, bus.done_count}
          !== {1'b1, 1'b0, 8'h52, 2'b00, exp_count}) begin
        bad++;
        $display("FAIL stall c=%0d: got v=%b id=%b y=%h rdy=%b cnt=%h want v=1 id=0 y=52 rdy=00 cnt=%h",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_y, {bus.req1_ready, bus.req0_ready},
                 bus.done_count, exp_count);
      end
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    step();
    exp_count = exp_count + 8'd1;
    total++;
    if ({bus.rsp_valid, bus.done_count, bus.rsp_y} !== {1'b0, exp_count, 8'h52}) begin
      bad++;
      $display("FAIL stall_release: got v=%b cnt=%h y=%h want v=0 cnt=%h y=52",
               bus.rsp_valid, bus.done_count, bus.rsp_y, exp_count);
    end
  endtask

  task automatic test_reset_mid_exec();
    bus.req0_valid = 1'b1;
    bus.req0_op    = 3'(OP_AND);
    bus.req0_a     = 8'hAA;
    bus.req0_b     = 8'hFF;
    #1;
    step();
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 8'd0;
    total++;
    if ({bus.rsp_valid, bus.done_count, bus.rsp_y} !== {1'b0, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL rst_exec: got v=%b cnt=%h y=%h want v=0 cnt=00 y=00",
               bus.rsp_valid, bus.done_count, bus.rsp_y);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_dropped c=%0d: got v=%b want 0", c, bus.rsp_valid);
      end
    end
    bus.req1_valid = 1'b1;
    bus.req1_op    = 3'(OP_XNOR);
    bus.req1_a     = 8'h0F;
    bus.req1_b     = 8'h33;
    #1;
    total++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      bad++;
      $display("FAIL rst_idle_ready: got %b want 10", {bus.req1_ready, bus.req0_ready});
    end
    step();
    bus.req1_valid = 1'b0;
    step();
    total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y} !== {1'b1, 1'b1, 8'hC3}) begin
      bad++;
      $display("FAIL rst_after_rsp: got v=%b id=%b y=%h want v=1 id=1 y=c3",
               bus.rsp_valid, bus.rsp_id, bus.rsp_y);
    end
    step();
    exp_count = exp_count + 8'd1;
  endtask

  task automatic test_operand_change();
    bus.req0_valid = 1'b1;
    bus.req0_op    = 3'(OP_XOR);
    bus.req0_a     = 8'hCA;
    bus.req0_b     = 8'h69;
    #1;
    step();
    bus.req0_valid = 1'b0;
    bus.req0_op    = 3'(OP_AND);
    bus.req0_a     = 8'hFF;
    bus.req0_b     = 8'h00;
    step();
    total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y} !== {1'b1, 1'b0, 8'hA3}) begin
      bad++;
      $display("FAIL operand_change: got v=%b id=%b y=%h want v=1 id=0 y=a3",
               bus.rsp_valid, bus.rsp_id, bus.rsp_y);
    end
    step();
    exp_count = exp_count + 8'd1;
  endtask

  task automatic test_wrap();
    int n;
    apply_reset();
    bus.req0_valid = 1'b1;
    bus.req0_op    = 3'(OP_OR);
    bus.req0_a     = 8'h01;
    bus.req0_b     = 8'h02;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 8) begin
        step();
        n++;
      end
      if (n >= 8) begin
        total++;
        bad++;
        $display("FAIL wrap_timeout i=%0d: got no rsp_valid within 8 cycles want rsp_valid", i);
        break;
      end
      step();
      exp_count = exp_count + 8'd1;
      if (i == 254) begin
        total++;
        if (bus.done_count !== 8'hFF) begin
          bad++;
          $display("FAIL wrap_255: got %h want ff", bus.done_count);
        end
      end
      if (i == 255) begin
        total++;
        if (bus.done_count !== 8'h00) begin
          bad++;
          $display("FAIL wrap_0: got %h want 00", bus.done_count);
        end
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    exp_count = 8'd0;
    test_reset();
    test_all_ops();
    test_stall();
    test_operand_change();
    test_reset_mid_exec();
    test_alternate();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
